// File: rtl/bcd_conv_sched_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [3:0] BLANK_CODE  = 4'hF;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // Requester index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_conv_sched_if.sv
// Request/result handshake bundle between requesters, the converter and the display driver.
interface bcd_conv_sched_if
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 5
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*BIN_W-1:0] req_bin;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_ready;
    logic [ID_W-1:0]          res_id;
    logic [DIGITS*4-1:0]      res_bcd;
    logic                     busy;

    modport master (
        output req_valid, req_bin, res_ready,
        input  req_ready, res_valid, res_id, res_bcd, busy
    );

    modport slave (
        input  req_valid, req_bin, res_ready,
        output req_ready, res_valid, res_id, res_bcd, busy
    );

endinterface

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, with wrap.
module rr_arbiter
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]           req,
    input  logic [id_width(NUM_REQ)-1:0] ptr,
    input  logic                         en,
    output logic [NUM_REQ-1:0]           gnt
);
    localparam int ID_W = id_width(NUM_REQ);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = ID_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shared sequential double-dabble converter serving NUM_REQ requesters round-robin.
// Optional BCD_LEADING_BLANK_EN replaces leading zero digits (above digit 0) with BLANK_CODE.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BIN_W   = 16,
    parameter int DIGITS  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_conv_sched_if.slave  bus
);
    localparam int ID_W  = id_width(NUM_REQ);
    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [BCD_W-1:0]   final_bcd;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               res_valid;
    logic [ID_W-1:0]    res_id;
    logic [BCD_W-1:0]   res_bcd;
    logic               busy;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  ((state == IDLE) && rst_n),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;
    assign bus.res_valid = res_valid;
    assign bus.res_id    = res_id;
    assign bus.res_bcd   = res_bcd;
    assign bus.busy      = busy;

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gnt_id = ID_W'(i);
    end

    // Add-3 correction, then the shift; bits carried out of the top digit are dropped.
    always_comb begin
        adj = '0;
        for (int d = 0; d < DIGITS; d++)
            adj[d*4 +: 4] = (acc[d*4 +: 4] >= ADD3_THRESH) ? acc[d*4 +: 4] + 4'd3 : acc[d*4 +: 4];
        shifted = {adj[BCD_W-2:0], shreg[BIN_W-1]};
    end

`ifdef BCD_LEADING_BLANK_EN
    logic lead;
    always_comb begin
        final_bcd = shifted;
        lead      = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && shifted[d*4 +: 4] == 4'd0) final_bcd[d*4 +: 4] = BLANK_CODE;
            else                                   lead = 1'b0;
        end
    end
`else
    assign final_bcd = shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            shreg     <= '0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_bcd   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    shreg  <= bus.req_bin[gnt_id*BIN_W +: BIN_W];
                    acc    <= '0;
                    res_id <= gnt_id;
                    cnt    <= CNT_W'(BIN_W);
                    rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    busy   <= 1'b1;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    acc   <= shifted;
                    shreg <= shreg << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        res_bcd   <= final_bcd;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.res_ready) begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed-vector bench for bcd_conv_sched; expectations queued at issue, checked by a monitor.
module tb_bcd_conv_sched;

    localparam int NUM_REQ = 2;
    localparam int BIN_W   = 16;
    localparam int DIGITS  = 5;

    typedef struct {
        int          id;
        logic [19:0] bcd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   cyc;
    int   acc_cyc;
    bit   prev_rv;
    bit   hs_prev;
    exp_t expq[$];

    bcd_conv_sched_if #(.NUM_REQ(NUM_REQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bcd_conv_sched #(.NUM_REQ(NUM_REQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Selects the hand-written plain or blanked expectation for the current build.
    function automatic logic [19:0] pick(input logic [19:0] plain, input logic [19:0] blank);
`ifdef BCD_LEADING_BLANK_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    // Monitor: latency on every rise, result contents on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
            hs_prev = 1'b0;
        end else begin
            if (|(bus.req_valid & bus.req_ready)) acc_cyc = cyc + 1;
            if (hs_prev) check("res_valid_drop", 32'(bus.res_valid), 32'd0);
            if (bus.res_valid && !prev_rv) check("latency", 32'(cyc - acc_cyc), 32'(BIN_W));
            hs_prev = 1'b0;
            if (bus.res_valid && bus.res_ready) begin
                hs_prev = 1'b1;
                if (expq.size() == 0) check("unexpected_result", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("res_id", 32'(bus.res_id), 32'(e.id));
                    check("res_bcd", 32'(bus.res_bcd), 32'(e.bcd));
                end
            end
            prev_rv = bus.res_valid;
        end
    end

    task automatic wait_grant(input int id);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                check("grant", 32'(bus.req_ready), 32'(1 << id));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [15:0] val, input logic [19:0] exp);
        @(posedge clk);
        #1;
        bus.req_bin[id*BIN_W +: BIN_W] = val;
        bus.req_valid[id] = 1'b1;
        expq.push_back('{id, exp});
        wait_grant(id);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        checks = 0; passes = 0; cyc = 0; acc_cyc = 0;
        prev_rv = 1'b0; hs_prev = 1'b0;
        bus.req_valid = '0;
        bus.req_bin   = '0;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_bcd", 32'(bus.res_bcd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        #22 rst_n = 1'b1;

        // Both requesters from reset: 0 first, then 1; ptr wraps back to 0.
        @(posedge clk);
        #1;
        bus.req_bin   = {16'd987, 16'd1234};
        bus.req_valid = 2'b11;
        expq.push_back('{0, pick(20'h01234, 20'hF1234)});
        expq.push_back('{1, pick(20'h00987, 20'hFF987)});
        wait_grant(0);
        wait_grant(1);
        drain();
        check("rr_ptr_wrap", 32'(dut.rr_ptr), 32'd0);
        @(posedge clk);
        #1;
        bus.req_bin   = {16'd50000, 16'd10};
        bus.req_valid = 2'b11;
        expq.push_back('{0, pick(20'h00010, 20'hFFF10)});
        expq.push_back('{1, pick(20'h50000, 20'h50000)});
        wait_grant(0);
        wait_grant(1);
        drain();

        // Single requests at the range extremes.
        issue(0, 16'd65535, pick(20'h65535, 20'h65535));
        issue(0, 16'd0, pick(20'h00000, 20'hFFFF0));
        drain();

        // Consumer stalls in DONE while another request waits.
        bus.res_ready = 1'b0;
        issue(0, 16'd1234, pick(20'h01234, 20'hF1234));
        bus.req_bin[BIN_W +: BIN_W] = 16'd987;
        bus.req_valid[1] = 1'b1;
        expq.push_back('{1, pick(20'h00987, 20'hFF987)});
        for (int i = 0; i < 40 && !bus.res_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.res_valid), 32'd1);
            check("stall_bcd", 32'(bus.res_bcd), 32'(pick(20'h01234, 20'hF1234)));
            check("stall_id", 32'(bus.res_id), 32'd0);
            check("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_grant(1);
        drain();

        // Reset pulse in the middle of SHIFT drops the conversion.
        @(posedge clk);
        #1;
        bus.req_bin[0 +: BIN_W] = 16'd777;
        bus.req_valid[0] = 1'b1;
        expq.push_back('{0, 20'h00777});
        wait_grant(0);
        bus.req_bin[BIN_W +: BIN_W] = 16'd4095;
        bus.req_valid[1] = 1'b1;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        expq.delete();
        check("mid_rst_valid", 32'(bus.res_valid), 32'd0);
        check("mid_rst_bcd", 32'(bus.res_bcd), 32'd0);
        check("mid_rst_id", 32'(bus.res_id), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_state", 32'(int'(dut.state)), 32'(int'(bcd_pkg::IDLE)));
        check("mid_rst_ptr", 32'(dut.rr_ptr), 32'd0);
        check("mid_rst_cnt", 32'(dut.cnt), 32'd0);
        #10 rst_n = 1'b1;
        expq.push_back('{1, pick(20'h04095, 20'hF4095)});
        wait_grant(1);
        drain();

        // Input changes after the accept edge must not leak into the result.
        issue(0, 16'd321, pick(20'h00321, 20'hFF321));
        bus.req_bin[0 +: BIN_W] = 16'd999;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
